// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmit path: mux select codes, line levels
// and the controller state encoding.
package uart_tx_pkg;

  // Mux select codes; the downstream TX mux decodes these same values.
  localparam logic [2:0] SEL_IDLE   = 3'd0;
  localparam logic [2:0] SEL_START  = 3'd1;
  localparam logic [2:0] SEL_DATA   = 3'd2;
  localparam logic [2:0] SEL_PARITY = 3'd3;
  localparam logic [2:0] SEL_STOP   = 3'd4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter; presents the current data bit
// and flags the last data bit of the frame.
module uart_tx_serializer #(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  serial_data,
  output logic                  done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [CNT_W-1:0]      cnt_reg;

  // Load takes priority; otherwise shift right with zero fill at the MSB.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
    if (gi == DATA_WIDTH - 1) begin : g_msb
      assign shift_next[gi] = load ? load_data[gi] : 1'b0;
    end else begin : g_lower
      assign shift_next[gi] = load ? load_data[gi] : shift_reg[gi+1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (load) begin
      shift_reg <= shift_next;
      cnt_reg   <= '0;
    end else if (shift) begin
      shift_reg <= shift_next;
      cnt_reg   <= cnt_reg + 1'b1;
    end
  end

  assign serial_data = shift_reg[0];
  assign done        = (cnt_reg == LAST_IDX);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop.
// Drives the TX mux select, the current data bit and the frame parity.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [2:0]            sel,
  output logic                  serial_data,
  output logic                  parity,
  output logic                  busy
);

  tx_state_t  state_reg;
  logic [2:0] sel_reg;
  logic       busy_reg;
  logic       par_en_q;
  logic       par_typ_q;
  logic       data_xor_q;
  logic       accept;
  logic       last_bit;

  assign accept = (state_reg == ST_IDLE) && data_valid;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .shift       (state_reg == ST_DATA),
    .load_data   (p_data),
    .serial_data (serial_data),
    .done        (last_bit)
  );

  // sel/busy are registered alongside the state so they always track it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      sel_reg    <= SEL_IDLE;
      busy_reg   <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      data_xor_q <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (data_valid) begin
            state_reg  <= ST_START;
            sel_reg    <= SEL_START;
            busy_reg   <= 1'b1;
            par_en_q   <= par_en;
            par_typ_q  <= par_typ;
            data_xor_q <= ^p_data;
          end
        end
        ST_START: begin
          state_reg <= ST_DATA;
          sel_reg   <= SEL_DATA;
        end
        ST_DATA: begin
          if (last_bit) begin
            if (par_en_q) begin
              state_reg <= ST_PARITY;
              sel_reg   <= SEL_PARITY;
            end else begin
              state_reg <= ST_STOP;
              sel_reg   <= SEL_STOP;
            end
          end
        end
        ST_PARITY: begin
          state_reg <= ST_STOP;
          sel_reg   <= SEL_STOP;
        end
        ST_STOP: begin
          state_reg <= ST_IDLE;
          sel_reg   <= SEL_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          sel_reg   <= SEL_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign sel    = sel_reg;
  assign busy   = busy_reg;
  // Both terms are registered at acceptance, so parity is stable per frame.
  assign parity = data_xor_q ^ par_typ_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed and randomized frame checks for uart_tx_ctrl against a
// frame-level reference built from the framing rules.
module tb_uart_tx_ctrl;
  import uart_tx_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] p_data = '0;
  logic         data_valid = 1'b0;
  logic         par_en = 1'b0;
  logic         par_typ = 1'b0;
  logic [2:0]   sel;
  logic         serial_data;
  logic         parity;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .sel         (sel),
    .serial_data (serial_data),
    .parity      (parity),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // noise: 0 none, 1 random input churn while busy, 2 data_valid pulse with 0x00.
  task automatic frame(input logic [7:0] d, input logic pe, input logic pt,
                       input int noise, input bit hold);
    logic [2:0] exp_sel[$];
    logic       exp_par;
    int         busy_cnt;
    int         n;
    busy_cnt = 0;
    exp_par  = logic'($countones(d) % 2) ^ pt;
    exp_sel.push_back(SEL_START);
    for (int k = 0; k < W; k++) exp_sel.push_back(SEL_DATA);
    if (pe) exp_sel.push_back(SEL_PARITY);
    exp_sel.push_back(SEL_STOP);
    exp_sel.push_back(SEL_IDLE);
    n = exp_sel.size();

    p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
    step();
    if (!hold) data_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("sel[%0d]", i), {5'd0, sel}, {5'd0, exp_sel[i]});
      check($sformatf("busy[%0d]", i), {7'd0, busy}, {7'd0, exp_sel[i] != SEL_IDLE});
      check($sformatf("parity[%0d]", i), {7'd0, parity}, {7'd0, exp_par});
      if (i <= W)
        check($sformatf("serial[%0d]", i), {7'd0, serial_data}, {7'd0, d[(i == 0) ? 0 : i-1]});
      if (busy === 1'b1) busy_cnt++;
      if (!hold) begin
        if (noise == 1 && i < n-2) begin
          p_data = 8'($urandom); data_valid = 1'($urandom_range(0, 1));
          par_en = 1'($urandom_range(0, 1)); par_typ = 1'($urandom_range(0, 1));
        end else if (noise == 2 && i == 3) begin
          p_data = 8'h00; data_valid = 1'b1;
        end else if (noise == 2 && i == 4) begin
          data_valid = 1'b0;
        end
        if (i == n-2) data_valid = 1'b0;
      end
      if (i < n-1) step();
    end
    check("busy_len", 8'(busy_cnt), 8'(2 + W + int'(pe)));
    $display("[TB] frame d=%02h par_en=%0d par_typ=%0d noise=%0d hold=%0d busy_cycles=%0d",
             d, pe, pt, noise, hold, busy_cnt);
  endtask

  initial begin
    step(); step();
    check("rst_sel", {5'd0, sel}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_serial", {7'd0, serial_data}, 8'd0);
    check("rst_parity", {7'd0, parity}, 8'd0);
    rst = 1'b1;
    step(); step();
    check("idle_sel", {5'd0, sel}, 8'd0);

    frame(8'hA5, 1'b1, 1'b0, 0, 1'b0);
    frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
    frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
    frame(8'hFF, 1'b1, 1'b0, 2, 1'b0);
    step();
    check("after_ignored_sel", {5'd0, sel}, 8'd0);

    // Back-to-back frames: data_valid stays high, one IDLE cycle between.
    frame(8'h81, 1'b0, 1'b0, 0, 1'b1);
    frame(8'h81, 1'b0, 1'b0, 0, 1'b1);
    data_valid = 1'b0;
    step();

    for (int f = 0; f < 20; f++) begin
      int gap;
      frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 1'b0);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) step();
    end

    // Asynchronous reset during DATA cycle 3.
    p_data = 8'h55; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("pre_rst_sel", {5'd0, sel}, {5'd0, SEL_DATA});
    check("pre_rst_parity", {7'd0, parity}, 8'd1);
    #2 rst = 1'b0;
    #1;
    check("async_sel", {5'd0, sel}, 8'd0);
    check("async_busy", {7'd0, busy}, 8'd0);
    check("async_serial", {7'd0, serial_data}, 8'd0);
    check("async_parity", {7'd0, parity}, 8'd0);
    $display("[TB] async reset during DATA of 55 applied");
    step(); step();
    #2 rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("post_rst_sel[%0d]", c), {5'd0, sel}, 8'd0);
      check($sformatf("post_rst_busy[%0d]", c), {7'd0, busy}, 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
